// File: rtl/spi_slave_16bit_if.sv
// Bus bundle for the SPI mode-0 slave: pin-side SPI signals plus the local
// word-level load/receive handshake.
interface spi_slave_16bit_if #(
    parameter int DATA_W = 16
);
    logic              sclk;
    logic              cs_n;
    logic              mosi;
    logic              miso;
    logic              miso_oe;
    logic [DATA_W-1:0] tx_data;
    logic              tx_load;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              frame_err;
    logic              busy;

    modport slave (
        input  sclk, cs_n, mosi, tx_data, tx_load,
        output miso, miso_oe, rx_data, rx_valid, frame_err, busy
    );

    modport master (
        output sclk, cs_n, mosi, tx_data, tx_load,
        input  miso, miso_oe, rx_data, rx_valid, frame_err, busy
    );
endinterface

// File: rtl/spi_slave_16bit.sv
// SPI mode-0 slave: oversamples sclk/cs_n/mosi on clk, shifts a DATA_W word out
// on miso MSB-first and captures DATA_W bits from mosi per frame.
module spi_slave_16bit #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_slave_16bit_if.slave     bus
);
    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_W);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q, cs_prev_d;

    state_t                 state_q, state_d;
    logic [DATA_W-1:0]      tx_buf_q, tx_buf_d;
    logic [DATA_W-1:0]      tx_sh_q, tx_sh_d;
    // The final bit is merged straight into rx_data, so DATA_W-1 bits suffice.
    logic [DATA_W-2:0]      rx_sh_q, rx_sh_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]      rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   busy_q, busy_d;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
        sclk_s      = sclk_sync_q[SYNC_STAGES-1];
        cs_s        = cs_sync_q[SYNC_STAGES-1];
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        sclk_rise   = sclk_s & ~sclk_prev_q;
        sclk_fall   = ~sclk_s & sclk_prev_q;
        cs_rise     = cs_s & ~cs_prev_q;
        cs_fall     = ~cs_s & cs_prev_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // cs_n release outranks any sclk edge seen in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (cs_fall) state_d = SHIFT;
            SHIFT: begin
                if (cs_rise)                                  state_d = IDLE;
                else if (sclk_rise && bit_cnt_q == LAST_BIT)  state_d = DONE;
            end
            DONE:  if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_buf_d    = bus.tx_load ? bus.tx_data : tx_buf_q;
        tx_sh_d     = tx_sh_q;
        rx_sh_d     = rx_sh_q;
        bit_cnt_d   = bit_cnt_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                busy_d  = 1'b0;
                tx_sh_d = '0;
                if (cs_fall) begin
                    tx_sh_d   = tx_buf_q;
                    rx_sh_d   = '0;
                    bit_cnt_d = '0;
                    busy_d    = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    frame_err_d = 1'b1;
                    busy_d      = 1'b0;
                    tx_sh_d     = '0;
                end else if (sclk_rise) begin
                    rx_sh_d = {rx_sh_q[DATA_W-3:0], mosi_s};
                    if (bit_cnt_q != FULL_CNT) bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        rx_data_d  = {rx_sh_q, mosi_s};
                        rx_valid_d = 1'b1;
                        tx_sh_d    = '0;
                    end
                end else if (sclk_fall) begin
                    tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
                end
            end
            DONE: begin
                // Clearing the shifter holds miso low for the rest of the frame.
                tx_sh_d = '0;
                if (cs_rise) busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_buf_q    <= '0;
            tx_sh_q     <= '0;
            rx_sh_q     <= '0;
            bit_cnt_q   <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            tx_buf_q    <= tx_buf_d;
            tx_sh_q     <= tx_sh_d;
            rx_sh_q     <= rx_sh_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.miso_oe   = ~cs_s;
    assign bus.miso      = tx_sh_q[DATA_W-1] & ~cs_s;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_spi_slave_16bit.sv
// Bench for spi_slave_16bit: a bench-side SPI master drives directed and random
// frames; a transaction-level model predicts miso bits, rx words and pulses.
module tb_spi_slave_16bit;
    logic clk = 1'b0;
    logic rst = 1'b1;

    spi_slave_16bit_if #(.DATA_W(16)) bus();

    spi_slave_16bit #(.DATA_W(16), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0] exp_tx_buf = 16'h0;
    logic [15:0] exp_rx     = 16'h0;
    logic [15:0] exp_q[$];
    int          valid_seen = 0;
    int          err_seen   = 0;
    logic        prev_v     = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [15:0] v);
        bus.tx_data = v;
        bus.tx_load = 1'b1;
        exp_tx_buf  = v;
        @(negedge clk);
        bus.tx_load = 1'b0;
    endtask

    task automatic do_reset(input int half);
        rst = 1'b1;
        #1;
        chk("rst_miso",      32'(bus.miso),      32'h0);
        chk("rst_miso_oe",   32'(bus.miso_oe),   32'h0);
        chk("rst_rx_data",   32'(bus.rx_data),   32'h0);
        chk("rst_rx_valid",  32'(bus.rx_valid),  32'h0);
        chk("rst_frame_err", 32'(bus.frame_err), 32'h0);
        chk("rst_busy",      32'(bus.busy),      32'h0);
        bus.cs_n   = 1'b1;
        bus.sclk   = 1'b0;
        bus.mosi   = 1'b0;
        exp_tx_buf = 16'h0;
        exp_rx     = 16'h0;
        exp_q.delete();
        prev_v     = 1'b0;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(2 * half);
    endtask

    // One frame from the bench master; miso is sampled just before each sclk rise.
    task automatic frame(input logic [15:0] word, input int nbits, input int half,
                         input int load_at, input logic [15:0] load_val,
                         input int rst_at, output logic [15:0] mw);
        logic [15:0] sent;
        int v0, e0;
        sent = exp_tx_buf;
        mw   = 16'h0;
        v0   = valid_seen;
        e0   = err_seen;
        if (nbits >= 16) exp_q.push_back(word);
        bus.cs_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = (i < 16) ? word[15-i] : 1'($urandom_range(0, 1));
            wait_clks(half);
            if (i == rst_at) begin
                do_reset(half);
                return;
            end
            chk("miso_bit", 32'(bus.miso), (i < 16) ? 32'(sent[15-i]) : 32'h0);
            if (i < 16) mw[15-i] = bus.miso;
            bus.sclk = 1'b1;
            if (i == load_at) begin
                load(load_val);
                wait_clks(half - 1);
            end else begin
                wait_clks(half);
            end
            if (i == 1) chk("busy_in_frame", 32'(bus.busy), 32'h1);
            bus.sclk = 1'b0;
        end
        wait_clks(half);
        bus.cs_n = 1'b1;
        wait_clks(2 * half + 2);
        chk("busy_after", 32'(bus.busy), 32'h0);
        chk("rx_valid_count", 32'(valid_seen - v0), (nbits >= 16) ? 32'h1 : 32'h0);
        chk("frame_err_count", 32'(err_seen - e0), (nbits < 16) ? 32'h1 : 32'h0);
    endtask

    // Per-cycle compare against the model, away from the active edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!rst) begin
                if (bus.rx_valid) begin
                    chk("rx_valid_width", 32'(prev_v), 32'h0);
                    valid_seen++;
                    chk("rx_valid_expected", 32'(exp_q.size() > 0), 32'h1);
                    if (exp_q.size() > 0) exp_rx = exp_q.pop_front();
                end
                chk("rx_data", 32'(bus.rx_data), 32'(exp_rx));
                if (!bus.miso_oe) chk("miso_when_off", 32'(bus.miso), 32'h0);
                if (bus.frame_err) begin
                    err_seen++;
                    chk("err_and_valid", 32'(bus.rx_valid), 32'h0);
                end
                prev_v = bus.rx_valid;
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] mw;
        logic [15:0] w;
        int nb, h, la, r;
        bus.sclk    = 1'b0;
        bus.cs_n    = 1'b1;
        bus.mosi    = 1'b0;
        bus.tx_data = 16'h0;
        bus.tx_load = 1'b0;
        wait_clks(1);
        #1;
        chk("reset_rx_data",  32'(bus.rx_data),  32'h0);
        chk("reset_busy",     32'(bus.busy),     32'h0);
        chk("reset_miso_oe",  32'(bus.miso_oe),  32'h0);
        chk("reset_rx_valid", 32'(bus.rx_valid), 32'h0);
        wait_clks(2);
        rst = 1'b0;
        wait_clks(4);

        load(16'hF0A5);
        frame(16'h3C5A, 16, 6, -1, 16'h0, -1, mw);
        chk("lit_miso_F0A5", 32'(mw), 32'h0000F0A5);
        chk("lit_rx_3C5A", 32'(bus.rx_data), 32'h00003C5A);

        frame(16'hFFFF, 7, 6, -1, 16'h0, -1, mw);
        chk("lit_rx_kept", 32'(bus.rx_data), 32'h00003C5A);
        frame(16'h1234, 16, 6, -1, 16'h0, -1, mw);
        chk("lit_rx_1234", 32'(bus.rx_data), 32'h00001234);

        load(16'hAAAA);
        frame(16'h0F0F, 16, 6, 8, 16'h5555, -1, mw);
        chk("lit_miso_AAAA", 32'(mw), 32'h0000AAAA);
        frame(16'h00FF, 16, 6, -1, 16'h0, -1, mw);
        chk("lit_miso_5555", 32'(mw), 32'h00005555);

        frame(16'hBEEF, 17, 6, -1, 16'h0, -1, mw);
        chk("lit_rx_BEEF", 32'(bus.rx_data), 32'h0000BEEF);

        load(16'h1357);
        frame(16'hCAFE, 16, 6, -1, 16'h0, 5, mw);
        chk("lit_rx_after_rst", 32'(bus.rx_data), 32'h0);
        frame(16'h0F0F, 16, 6, -1, 16'h0, -1, mw);
        chk("lit_miso_zero", 32'(mw), 32'h0);
        chk("lit_rx_0F0F", 32'(bus.rx_data), 32'h00000F0F);

        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 1) == 1) load(16'($urandom));
            w  = 16'($urandom);
            h  = $urandom_range(5, 8);
            r  = $urandom_range(0, 9);
            la = -1;
            if (r < 6)       nb = 16;
            else if (r == 6) nb = $urandom_range(3, 15);
            else if (r == 7) nb = $urandom_range(17, 18);
            else begin
                nb = 16;
                la = $urandom_range(0, 15);
            end
            frame(w, nb, h, la, 16'($urandom), -1, mw);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
